// File: rtl/dram_arbiter.sv
// Round-robin arbiter sharing one single-port 16-bit DRAM among NUM_CORES cores.
// Each access runs IDLE -> ACCESS -> RESP -> DONE with registered DRAM drive.
module dram_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int MEM_DEPTH = 1025
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_CORES-1:0]      core_req,
    input  logic [NUM_CORES-1:0]      core_we,
    input  logic [16*NUM_CORES-1:0]   core_addr,
    input  logic [16*NUM_CORES-1:0]   core_wdata,
    output logic [NUM_CORES-1:0]      core_done,
    output logic [15:0]               core_rdata,
    output logic                      busy,
    output logic                      mem_write_en,
    output logic [15:0]               mem_addr,
    output logic [15:0]               mem_data_in,
    input  logic [15:0]               mem_data_out
);

    localparam int GW = $clog2(NUM_CORES);
    localparam logic [16:0] LP_DEPTH = 17'(MEM_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [GW-1:0]   r_grant;
    logic [GW-1:0]   r_rr_ptr;
    logic            r_rd;
    logic            r_rd_ok;

    logic            w_any;
    logic [GW-1:0]   w_sel;
    logic            w_we;
    logic [15:0]     w_addr;
    logic [15:0]     w_wdata;
    logic            w_in_range;
    logic [GW-1:0]   w_next_ptr;
    int              w_idx;

    // First requester at or above rr_ptr, wrapping modulo NUM_CORES
    always_comb begin
        w_any   = 1'b0;
        w_sel   = '0;
        w_we    = 1'b0;
        w_addr  = '0;
        w_wdata = '0;
        w_idx   = 0;
        for (int i = 0; i < NUM_CORES; i++) begin
            w_idx = (int'(r_rr_ptr) + i) % NUM_CORES;
            if (!w_any && core_req[w_idx]) begin
                w_any   = 1'b1;
                w_sel   = GW'(w_idx);
                w_we    = core_we[w_idx];
                w_addr  = core_addr[16*w_idx +: 16];
                w_wdata = core_wdata[16*w_idx +: 16];
            end
        end
    end

    assign w_in_range = {1'b0, w_addr} < LP_DEPTH;
    assign w_next_ptr = (r_grant == GW'(NUM_CORES - 1)) ? '0 : r_grant + 1'b1;
    assign busy       = (r_state != S_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_grant      <= '0;
            r_rr_ptr     <= '0;
            r_rd         <= 1'b0;
            r_rd_ok      <= 1'b0;
            mem_write_en <= 1'b0;
            mem_addr     <= '0;
            mem_data_in  <= '0;
            core_done    <= '0;
            core_rdata   <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_grant      <= w_sel;
                        mem_addr     <= w_addr;
                        mem_data_in  <= w_wdata;
                        mem_write_en <= w_we & w_in_range;
                        r_rd         <= ~w_we;
                        r_rd_ok      <= ~w_we & w_in_range;
                        r_state      <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    mem_write_en <= 1'b0;
                    r_state      <= S_RESP;
                end
                S_RESP: begin
                    // Writes leave the last read data untouched
                    if (r_rd) begin
                        core_rdata <= r_rd_ok ? mem_data_out : 16'h0000;
                    end
                    core_done <= NUM_CORES'(1) << r_grant;
                    r_rr_ptr  <= w_next_ptr;
                    r_state   <= S_DONE;
                end
                S_DONE: begin
                    core_done <= '0;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dram_arbiter.sv
// Scoreboard bench for dram_arbiter with a behavioural DRAM model.
// Stimulus pushes expected completions; a negedge monitor pops and compares.
module tb_dram_arbiter;

    localparam int N     = 4;
    localparam int DEPTH = 1025;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      core_req;
    logic [N-1:0]      core_we;
    logic [16*N-1:0]   core_addr;
    logic [16*N-1:0]   core_wdata;
    logic [N-1:0]      core_done;
    logic [15:0]       core_rdata;
    logic              busy;
    logic              mem_write_en;
    logic [15:0]       mem_addr;
    logic [15:0]       mem_data_in;
    logic [15:0]       mem_data_out;

    typedef struct {
        int          core;
        bit          rd;
        logic [15:0] data;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          wr_cnt   = 0;
    logic [15:0] dram [0:DEPTH-1];
    logic [15:0] m_v;
    logic        pl_en  = 1'b0;
    logic        pl_clr = 1'b0;
    logic [15:0] pl_addr = '0;
    logic [15:0] pl_data = '0;

    dram_arbiter #(.NUM_CORES(N), .MEM_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .core_req     (core_req),
        .core_we      (core_we),
        .core_addr    (core_addr),
        .core_wdata   (core_wdata),
        .core_done    (core_done),
        .core_rdata   (core_rdata),
        .busy         (busy),
        .mem_write_en (mem_write_en),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // DRAM: registered read of addr, write when write_en; out-of-range reads give junk
    always @(posedge clk) begin
        if (pl_clr) begin
            for (int i = 0; i < DEPTH; i++) dram[i] = 16'h0000;
        end else if (pl_en) begin
            dram[pl_addr] = pl_data;
        end
        m_v = (mem_addr < 16'(DEPTH)) ? dram[mem_addr] : 16'hDEAD;
        if (mem_write_en && mem_addr < 16'(DEPTH)) dram[mem_addr] = mem_data_in;
        mem_data_out <= m_v;
    end

    always @(negedge clk) begin
        if (mem_write_en) wr_cnt++;
        if (!reset && core_done != '0) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected: done=%b expected none", core_done);
            end else begin
                mon_e = sb.pop_front();
                if (core_done !== (N'(1) << mon_e.core)) begin
                    failures++;
                    $display("FAIL sb_done: got %b expected core %0d", core_done, mon_e.core);
                end
                if (mon_e.rd) begin
                    checks++;
                    if (core_rdata !== mon_e.data) begin
                        failures++;
                        $display("FAIL sb_rdata: got %h expected %h", core_rdata, mon_e.data);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        pl_addr = a;
        pl_data = d;
        pl_en   = 1'b1;
        @(negedge clk);
        pl_en   = 1'b0;
    endtask

    task automatic set_core(input int c, input logic req, input logic we,
                            input logic [15:0] addr, input logic [15:0] wdata);
        core_req[c]            = req;
        core_we[c]             = we;
        core_addr[16*c +: 16]  = addr;
        core_wdata[16*c +: 16] = wdata;
    endtask

    task automatic wait_done(input int c, output int n);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            n++;
            if (core_done[c]) return;
        end
        checks++;
        failures++;
        $display("FAIL timeout_done: core %0d got no done expected done", c);
        n = -1;
    endtask

    task automatic wait_any(output int c);
        c = -1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            for (int b = 0; b < N; b++) if (core_done[b]) c = b;
            if (c >= 0) return;
        end
        checks++;
        failures++;
        $display("FAIL timeout_any: got no done expected done");
    endtask

    initial begin
        int n;
        int nb;
        int c;
        int w0;
        int tprev;
        reset      = 1'b1;
        core_req   = '0;
        core_we    = '0;
        core_addr  = '0;
        core_wdata = '0;
        pl_clr     = 1'b1;
        @(negedge clk);
        pl_clr = 1'b0;
        check("rst_we", {31'b0, mem_write_en}, 0);
        check("rst_addr", {16'b0, mem_addr}, 0);
        check("rst_din", {16'b0, mem_data_in}, 0);
        check("rst_done", {28'b0, core_done}, 0);
        check("rst_rdata", {16'b0, core_rdata}, 0);
        check("rst_busy", {31'b0, busy}, 0);
        reset = 1'b0;

        preload(16'd5, 16'h00AB);
        for (int i = 0; i < 4; i++) preload(16'(200 + i), 16'(16'hA000 + i));
        preload(16'd10, 16'h0A0A);
        preload(16'd13, 16'h0D0D);
        preload(16'd1024, 16'h4321);
        preload(16'd7, 16'h0707);

        // single read: latency and busy width
        sb.push_back('{0, 1'b1, 16'h00AB});
        @(negedge clk);
        set_core(0, 1'b1, 1'b0, 16'd5, 16'h0);
        n  = 0;
        nb = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            n++;
            if (busy) nb++;
            if (core_done[0]) break;
        end
        set_core(0, 1'b0, 1'b0, 16'd5, 16'h0);
        check("t1_latency", n, 3);
        check("t1_busy_cycles", nb, 3);
        @(negedge clk);
        check("t1_done_low", {28'b0, core_done}, 0);
        check("t1_busy_low", {31'b0, busy}, 0);

        // write then read back
        w0 = wr_cnt;
        sb.push_back('{2, 1'b0, 16'h0});
        set_core(2, 1'b1, 1'b1, 16'd100, 16'h1234);
        wait_done(2, n);
        check("t2_rdata_hold", {16'b0, core_rdata}, 32'h00AB);
        set_core(2, 1'b0, 1'b0, 16'd100, 16'h0);
        @(negedge clk);
        check("t2_we_pulses", wr_cnt - w0, 1);
        check("t2_dram", {16'b0, dram[100]}, 32'h1234);
        sb.push_back('{2, 1'b1, 16'h1234});
        set_core(2, 1'b1, 1'b0, 16'd100, 16'h0);
        wait_done(2, n);
        set_core(2, 1'b0, 1'b0, 16'd100, 16'h0);

        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;

        // four simultaneous reads from rr_ptr 0
        for (int i = 0; i < 4; i++) begin
            sb.push_back('{i, 1'b1, 16'(16'hA000 + i)});
            set_core(i, 1'b1, 1'b0, 16'(200 + i), 16'h0);
        end
        tprev = 0;
        for (int j = 0; j < 4; j++) begin
            wait_any(c);
            check("t3_order", c, j);
            if (j > 0) check("t3_gap", cyc - tprev, 4);
            tprev = cyc;
            if (c >= 0) set_core(c, 1'b0, 1'b0, 16'h0, 16'h0);
        end

        // cores 0 and 3 hold req continuously
        @(negedge clk);
        for (int j = 0; j < 4; j++) begin
            sb.push_back('{(j % 2 == 1) ? 3 : 0, 1'b1, (j % 2 == 1) ? 16'h0D0D : 16'h0A0A});
        end
        set_core(0, 1'b1, 1'b0, 16'd10, 16'h0);
        set_core(3, 1'b1, 1'b0, 16'd13, 16'h0);
        for (int j = 0; j < 4; j++) begin
            wait_any(c);
            check("t4_alternate", c, (j % 2 == 1) ? 3 : 0);
        end
        set_core(0, 1'b0, 1'b0, 16'h0, 16'h0);
        set_core(3, 1'b0, 1'b0, 16'h0, 16'h0);

        // out-of-range write and read
        @(negedge clk);
        w0 = wr_cnt;
        sb.push_back('{1, 1'b0, 16'h0});
        set_core(1, 1'b1, 1'b1, 16'd1025, 16'hFFFF);
        wait_done(1, n);
        check("t5_wr_latency", n, 3);
        set_core(1, 1'b0, 1'b0, 16'd1025, 16'h0);
        @(negedge clk);
        check("t5_no_we", wr_cnt - w0, 0);
        sb.push_back('{1, 1'b1, 16'h0000});
        set_core(1, 1'b1, 1'b0, 16'd1025, 16'h0);
        wait_done(1, n);
        set_core(1, 1'b0, 1'b0, 16'd1025, 16'h0);
        check("t5_dram1024", {16'b0, dram[1024]}, 32'h4321);

        // reset while a write sits in ACCESS
        @(negedge clk);
        set_core(0, 1'b1, 1'b1, 16'd7, 16'h5555);
        @(negedge clk);
        check("t6_we_access", {31'b0, mem_write_en}, 1);
        check("t6_busy_access", {31'b0, busy}, 1);
        #2;
        reset = 1'b1;
        #1;
        check("t6_we_drop", {31'b0, mem_write_en}, 0);
        check("t6_busy_drop", {31'b0, busy}, 0);
        check("t6_addr_clr", {16'b0, mem_addr}, 0);
        set_core(0, 1'b0, 1'b0, 16'h0, 16'h0);
        @(negedge clk);
        check("t6_no_done", {28'b0, core_done}, 0);
        reset = 1'b0;
        check("t6_dram7", {16'b0, dram[7]}, 32'h0707);
        sb.push_back('{0, 1'b1, 16'h0707});
        sb.push_back('{3, 1'b1, 16'h0D0D});
        set_core(0, 1'b1, 1'b0, 16'd7, 16'h0);
        set_core(3, 1'b1, 1'b0, 16'd13, 16'h0);
        wait_any(c);
        check("t6_rr_first", c, 0);
        set_core(0, 1'b0, 1'b0, 16'h0, 16'h0);
        wait_any(c);
        check("t6_rr_second", c, 3);
        set_core(3, 1'b0, 1'b0, 16'h0, 16'h0);

        repeat (4) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
